// File: rtl/bn_input_fifo_if.sv
// bn_input_fifo_if: MAC write port, batch_norm dispatch port and FIFO status.
interface bn_input_fifo_if #(
  parameter int DATA_WIDTH   = 16,
  parameter int DEPTH        = 16,
  parameter int NUM_CHANNELS = 8
);
  logic                            wr_en;
  logic [DATA_WIDTH-1:0]           wr_data;
  logic                            full;
  logic                            almost_full;
  logic                            empty;
  logic [$clog2(DEPTH):0]          count;
  logic                            overflow;
  logic                            bn_ready;
  logic                            bnfifo_read_flag;
  logic [DATA_WIDTH-1:0]           bn_input;
  logic [$clog2(NUM_CHANNELS)-1:0] chan_idx;
  logic                            last_in_channel;
  modport master (
    output wr_en, wr_data, bn_ready,
    input  full, almost_full, empty, count, overflow, bnfifo_read_flag, bn_input, chan_idx, last_in_channel
  );
  modport slave (
    input  wr_en, wr_data, bn_ready,
    output full, almost_full, empty, count, overflow, bnfifo_read_flag, bn_input, chan_idx, last_in_channel
  );
endinterface

// File: rtl/bn_input_fifo.sv
// bn_input_fifo: elastic buffer feeding batch_norm one sample per ready handshake.
// Optional channel tagging is built when BN_FIFO_CHAN_TRACK_EN is defined.
module bn_input_fifo #(
  parameter int DATA_WIDTH         = 16,
  parameter int DEPTH              = 16,
  parameter int AFULL_THRESH       = DEPTH - 2,
  parameter int PIXELS_PER_CHANNEL = 64,
  parameter int NUM_CHANNELS       = 8
) (
  input logic clk,
  input logic rst,
  bn_input_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CNW = AW + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY} state_t;
  state_t state, state_nxt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CNW-1:0] count;
  logic overflow;
  logic [DATA_WIDTH-1:0] bn_input;
  logic full, empty, push, pop;
  assign full  = count == CNW'(DEPTH);
  assign empty = count == '0;
  // full is taken from the pre-edge count, so a pop never makes room for a same-edge write
  assign push  = bus.wr_en && !full;
  assign pop   = state == IDLE && bus.bn_ready && !empty;
  always_comb begin
    state_nxt = state == IDLE  ? (pop ? ISSUE : IDLE) :
                state == ISSUE ? WAIT_BUSY :
                (bus.bn_ready ? WAIT_BUSY : IDLE);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      bn_input <= '0;
    end else begin
      state <= state_nxt;
      count <= count + CNW'(push) - CNW'(pop);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (pop) bn_input <= mem[rd_ptr];
      if (bus.wr_en && full) overflow <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.wr_data;
  end
  assign bus.full             = full;
  assign bus.empty            = empty;
  assign bus.count            = count;
  assign bus.almost_full      = count >= CNW'(AFULL_THRESH);
  assign bus.overflow         = overflow;
  assign bus.bn_input         = bn_input;
  assign bus.bnfifo_read_flag = state == ISSUE;
`ifdef BN_FIFO_CHAN_TRACK_EN
  localparam int PW = $clog2(PIXELS_PER_CHANNEL);
  localparam int CW = $clog2(NUM_CHANNELS);
  logic [PW-1:0] pix_cnt;
  logic [CW-1:0] chan_cnt, chan_idx;
  logic last_in_channel, at_last;
  assign at_last = pix_cnt == PW'(PIXELS_PER_CHANNEL - 1);
  // chan_cnt is the channel of the next pop; chan_idx tags the sample on bn_input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_cnt         <= '0;
      chan_cnt        <= '0;
      chan_idx        <= '0;
      last_in_channel <= 1'b0;
    end else if (pop) begin
      chan_idx        <= chan_cnt;
      last_in_channel <= at_last;
      pix_cnt         <= at_last ? '0 : pix_cnt + PW'(1);
      if (at_last) chan_cnt <= chan_cnt == CW'(NUM_CHANNELS - 1) ? '0 : chan_cnt + CW'(1);
    end
  end
  assign bus.chan_idx        = chan_idx;
  assign bus.last_in_channel = last_in_channel;
`else
  assign bus.chan_idx        = '0;
  assign bus.last_in_channel = 1'b0;
`endif
endmodule

// File: tb/tb_bn_input_fifo.sv
// tb_bn_input_fifo: table vectors plus queue-based reference model for bn_input_fifo.
module tb_bn_input_fifo;
  localparam int DW = 16;
  localparam int DEPTH = 16;
  localparam int PPC = 4;
  localparam int NC = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  bn_input_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_CHANNELS(NC)) bus ();
  bn_input_fifo #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(DEPTH - 2),
    .PIXELS_PER_CHANNEL(PPC), .NUM_CHANNELS(NC)
  ) dut (.clk(clk), .rst(rst), .bus(bus));
  int q[$];
  bit m_ovf, m_rel, m_flag, m_last;
  int m_edge, m_pop_edge, m_ndisp, m_chan;
  logic [DW-1:0] m_in;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  task automatic check_all(input string tag);
    chk({tag, ".count"}, 32'(bus.count), q.size());
    chk({tag, ".empty"}, 32'(bus.empty), 32'(q.size() == 0));
    chk({tag, ".full"}, 32'(bus.full), 32'(q.size() == DEPTH));
    chk({tag, ".almost_full"}, 32'(bus.almost_full), 32'(q.size() >= DEPTH - 2));
    chk({tag, ".overflow"}, 32'(bus.overflow), 32'(m_ovf));
    chk({tag, ".flag"}, 32'(bus.bnfifo_read_flag), 32'(m_flag));
    chk({tag, ".bn_input"}, 32'(bus.bn_input), 32'(m_in));
    chk({tag, ".chan_idx"}, 32'(bus.chan_idx), m_chan);
    chk({tag, ".last"}, 32'(bus.last_in_channel), 32'(m_last));
  endtask
  task automatic model_clear();
    q.delete();
    m_ovf = 0; m_rel = 1; m_flag = 0; m_last = 0;
    m_pop_edge = -10; m_ndisp = 0; m_chan = 0; m_in = '0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_data = '0; bus.bn_ready = 1'b0;
    #1;
    model_clear();
    check_all("rst");
    @(posedge clk);
    #1 rst = 1'b0;
  endtask
  // one clock: drive inputs, let the edge happen, advance the model, compare
  task automatic step(input bit we, input logic [DW-1:0] wd, input bit rdy);
    bit do_pop, do_push;
    bus.wr_en = we; bus.wr_data = wd; bus.bn_ready = rdy;
    @(posedge clk);
    m_edge++;
    do_pop  = m_rel && rdy && q.size() > 0;
    do_push = we && q.size() < DEPTH;
    if (we && q.size() == DEPTH) m_ovf = 1;
    m_flag = do_pop;
    if (!m_rel && !rdy && m_edge > m_pop_edge + 1) m_rel = 1;
    if (do_pop) begin
      m_in = DW'(q.pop_front());
`ifdef BN_FIFO_CHAN_TRACK_EN
      m_chan = (m_ndisp / PPC) % NC;
      m_last = (m_ndisp % PPC) == PPC - 1;
`endif
      m_ndisp++;
      m_rel = 0;
      m_pop_edge = m_edge;
    end
    if (do_push) q.push_back(int'(wd));
    #1 check_all("step");
  endtask
  // batch_norm stand-in: ready stays high 2 cycles after each flag, then low 4
  task automatic run_bn(input int cycles);
    int cnt = 0;
    bit rdy = 1;
    for (int i = 0; i < cycles; i++) begin
      step(1'b0, '0, rdy);
      if (m_flag) cnt = 6;
      rdy = (cnt == 0) || (cnt > 4);
      if (cnt > 0) cnt--;
    end
  endtask
  typedef struct {
    bit we;
    logic [DW-1:0] wd;
    bit rdy;
    int ecount;
    bit eflag;
    logic [DW-1:0] ein;
  } vec_t;
  vec_t tv[10];
  initial begin
    tv[0] = '{1, 16'h2000, 0, 1, 0, 16'h0000};
    tv[1] = '{1, 16'h1800, 0, 2, 0, 16'h0000};
    tv[2] = '{1, 16'hF000, 0, 3, 0, 16'h0000};
    tv[3] = '{0, 16'h0000, 1, 2, 1, 16'h2000};
    tv[4] = '{0, 16'h0000, 1, 2, 0, 16'h2000};
    tv[5] = '{0, 16'h0000, 0, 2, 0, 16'h2000};
    tv[6] = '{0, 16'h0000, 1, 1, 1, 16'h1800};
    tv[7] = '{0, 16'h0000, 0, 1, 0, 16'h1800};
    tv[8] = '{0, 16'h0000, 0, 1, 0, 16'h1800};
    tv[9] = '{0, 16'h0000, 1, 0, 1, 16'hF000};
    m_edge = 0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(tv[i].we, tv[i].wd, tv[i].rdy);
      chk($sformatf("tv%0d.count", i), 32'(bus.count), tv[i].ecount);
      chk($sformatf("tv%0d.flag", i), 32'(bus.bnfifo_read_flag), 32'(tv[i].eflag));
      chk($sformatf("tv%0d.bn_input", i), 32'(bus.bn_input), 32'(tv[i].ein));
    end
    run_bn(10);
    do_reset();
    for (int i = 0; i < DEPTH + 2; i++) step(1'b1, DW'(16'h100 + i), 1'b0);
    run_bn(130);
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(16'h300 + i), 1'b0);
    step(1'b1, 16'hDEAD, 1'b1);
    chk("full_wr_pop.overflow", 32'(bus.overflow), 32'd1);
    chk("full_wr_pop.count", 32'(bus.count), DEPTH - 1);
    run_bn(130);
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, DW'(16'h500 + i), 1'b0);
    step(1'b1, 16'h0555, 1'b1);
    chk("five_wr_pop.count", 32'(bus.count), 32'd5);
    run_bn(60);
    do_reset();
    for (int i = 0; i < 9; i++) step(1'b1, DW'(16'h700 + i), 1'b0);
    run_bn(80);
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, DW'(16'h900 + i), 1'b0);
    step(1'b0, '0, 1'b1);
    chk("issue.flag", 32'(bus.bnfifo_read_flag), 32'd1);
    chk("issue.count", 32'(bus.count), 32'd4);
    do_reset();
    step(1'b0, '0, 1'b0);
    step(1'b1, 16'h0ABC, 1'b1);
    step(1'b0, '0, 1'b1);
    chk("post_rst.bn_input", 32'(bus.bn_input), 32'h0ABC);
    do_reset();
    for (int i = 0; i < 1500; i++)
      step(($urandom_range(0, 99) < 45), DW'($urandom), ($urandom_range(0, 99) < 50));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
